palindrome_gen: RTL and testbench

PALINDROME_GEN -- requirements
Module: palindrome_gen

---
 rtl/palgen_pkg.sv | 35 +++
 rtl/palgen_mirror.sv | 28 ++
 rtl/palindrome_gen.sv | 132 +++++++++++++
 tb/tb_palindrome_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palgen_pkg.sv
// -----------------------------------------------------------------------------
// palgen_pkg
// Shared types and helpers for the bit-palindrome generator.
//   state_t     : sequencing FSM states (IDLE / RUN / DONE)
//   MAX_SEED_W  : widest seed the bit_reverse helper supports
//   bit_reverse : reverses the low w bits of v; bits at and above w are zero
// -----------------------------------------------------------------------------
package palgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_SEED_W = 32;
    localparam int IDX_W      = $clog2(MAX_SEED_W);

    // A package function cannot take a parameter, so the width is passed in
    // as an argument and the result is sized for the widest supported seed.
    function automatic logic [MAX_SEED_W-1:0] bit_reverse(
        input logic [MAX_SEED_W-1:0] v,
        input int                    w
    );
        logic [MAX_SEED_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_SEED_W; i++) begin
            if (i < w) begin
                r[IDX_W'(i)] = v[IDX_W'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/palgen_mirror.sv
// -----------------------------------------------------------------------------
// palgen_mirror
// Purely combinational: turns a WIDTH/2-bit seed into the WIDTH-bit
// palindrome {seed, bitreverse(seed)}.
// Ports:
//   seed [WIDTH/2-1:0] : seed value (upper half of the word)
//   word [WIDTH-1:0]   : resulting bit-palindrome
// -----------------------------------------------------------------------------
module palgen_mirror #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH/2-1:0] seed,
    output logic [WIDTH-1:0]   word
);
    import palgen_pkg::*;

    localparam int H = WIDTH / 2;

    logic [H-1:0] rev;

    // NOTE: always_comb assigns rev on every path, so no latch can form.
    always_comb begin
        rev = H'(bit_reverse(MAX_SEED_W'(seed), H));
    end

    assign word = {seed, rev};

endmodule

// File: rtl/palindrome_gen.sv
// -----------------------------------------------------------------------------
// palindrome_gen
// Enumerates every WIDTH-bit bit-palindrome {h, bitreverse(h)} over a
// valid/ready stream, one beat per seed value h, in monotonic seed order.
// Optional feature macro: PALGEN_DESC_EN adds the desc input for descending
// enumeration; without it the order is always ascending.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : begin enumeration (sampled in IDLE; wins over stop)
//   stop      : abort enumeration (sampled in RUN; wins over the handshake)
//   out_ready : consumer ready
//   desc      : (PALGEN_DESC_EN only) descending order, sampled with start
//   out_valid : out_data holds a valid palindrome
//   out_data  : palindrome word, zero outside RUN
//   out_last  : final beat of the sequence
//   busy      : high while in RUN
//   done      : one-cycle pulse after the last beat is consumed
// -----------------------------------------------------------------------------
module palindrome_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             out_ready,
`ifdef PALGEN_DESC_EN
    input  logic             desc,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    import palgen_pkg::*;

    localparam int           H        = WIDTH / 2;
    localparam logic [H-1:0] SEED_MAX = '1;

    state_t       state;
    logic [H-1:0] h;
    logic [H-1:0] last_seed;
    logic [H-1:0] h_step;
    logic [WIDTH-1:0] word;
    logic         beat;

`ifdef PALGEN_DESC_EN
    logic desc_q;

    assign last_seed = desc_q ? '0 : SEED_MAX;
    assign h_step    = desc_q ? h - H'(1) : h + H'(1);
`else
    assign last_seed = SEED_MAX;
    assign h_step    = h + H'(1);
`endif

    palgen_mirror #(.WIDTH(WIDTH)) u_mirror (
        .seed (h),
        .word (word)
    );

    assign beat = out_valid & out_ready;

    // Both are decoded from registered state only; gating with out_valid
    // zeroes the word and the last flag outside RUN, including right at reset.
    assign out_data = out_valid ? word : '0;
    assign out_last = out_valid && (h == last_seed);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            h         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PALGEN_DESC_EN
            desc_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
`ifdef PALGEN_DESC_EN
                        desc_q    <= desc;
                        h         <= desc ? SEED_MAX : '0;
`else
                        h         <= '0;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        h         <= '0;
                    end else if (beat) begin
                        if (out_last) begin
                            // Hold h at its final value: the run ends here
                            // rather than wrapping into a second pass.
                            state     <= DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            h <= h_step;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    h     <= '0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    h         <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palindrome_gen.sv
// -----------------------------------------------------------------------------
// tb_palindrome_gen
// Self-checking bench for palindrome_gen (WIDTH=8). Expected words come from
// an arithmetic model of the palindrome rule; every observed word is also
// checked to equal its own bit-reversal.
// -----------------------------------------------------------------------------
module tb_palindrome_gen;

    localparam int WIDTH = 8;
    localparam int H     = WIDTH / 2;
    localparam int N     = 1 << H;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             out_ready;
`ifdef PALGEN_DESC_EN
    logic             desc;
`endif
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    palindrome_gen #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .out_ready (out_ready),
`ifdef PALGEN_DESC_EN
        .desc      (desc),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Upper half is the index itself, lower half its mirror built bit by bit.
    function automatic logic [WIDTH-1:0] model_word(input int k);
        int r;
        r = 0;
        for (int b = 0; b < H; b++) r = r * 2 + ((k >> b) & 1);
        return WIDTH'(k * N + r);
    endfunction

    function automatic bit is_pal(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++)
            if (w[i] !== w[WIDTH-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
`ifdef PALGEN_DESC_EN
        desc = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b busy=%b done=%b, want all 0",
                     out_valid, out_data, out_last, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_wait: got valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
    task automatic test_stream(input int mode, input bit dsc);
        int k;
        int cyc;
        logic [WIDTH-1:0] exp;
        start_pulse();
        k = 0;
        cyc = 0;
        while (k < N && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            exp = model_word(dsc ? N - 1 - k : k);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp || out_last !== (k == N - 1) ||
                busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_m%0d_beat%0d: got valid=%b data=%h last=%b busy=%b done=%b, want 1 %h %b 1 0",
                         mode, k, out_valid, out_data, out_last, busy, done, exp, (k == N - 1));
            end
            vectors++;
            if (!is_pal(out_data)) begin
                miscompares++;
                $display("FAIL palindrome_m%0d: got %b, want a bit-palindrome", mode, out_data);
            end
            if (out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (k < N) begin
            miscompares++;
            $display("FAIL stream_timeout_m%0d: got %0d beats, want %0d", mode, k, N);
        end
        #1;
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_data !== '0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_done_m%0d: got done=%b valid=%b busy=%b data=%h last=%b, want 1 0 0 00 0",
                     mode, done, out_valid, busy, out_data, out_last);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_done_pulse_m%0d: got done=%b valid=%b, want 0 0", mode, done, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stop();
        int k;
        int cyc;
        out_ready = 1'b1;
        start_pulse();
        k = 0;
        cyc = 0;
        while (k < 3 && cyc < 50) begin
            #1;
            vectors++;
            if (out_data !== model_word(k)) begin
                miscompares++;
                $display("FAIL stop_pre_beat%0d: got %h, want %h", k, out_data, model_word(k));
            end
            if (out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        stop = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== model_word(3)) begin
            miscompares++;
            $display("FAIL stop_fourth_beat: got valid=%b data=%h, want 1 %h", out_valid, out_data, model_word(3));
        end
        @(negedge clk);
        stop = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_data !== '0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_abort: got valid=%b busy=%b done=%b data=%h last=%b, want 0 0 0 00 0",
                     out_valid, busy, done, out_data, out_last);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stop = 1'b1;   // stop alone in IDLE has no effect
            #1;
            vectors++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL stop_idle_%0d: got done=%b valid=%b busy=%b, want 0 0 0", i, done, out_valid, busy);
            end
        end
        // start and stop together in IDLE: start wins, run restarts at 0
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== model_word(0)) begin
            miscompares++;
            $display("FAIL start_wins: got valid=%b data=%h, want 1 %h", out_valid, out_data, model_word(0));
        end
        @(negedge clk);
        start = 1'b1;   // must be ignored in RUN
        #1;
        vectors++;
        if (out_data !== model_word(1)) begin
            miscompares++;
            $display("FAIL run_beat1: got %h, want %h", out_data, model_word(1));
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== model_word(2)) begin
            miscompares++;
            $display("FAIL start_ignored_in_run: got valid=%b data=%h, want 1 %h", out_valid, out_data, model_word(2));
        end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_cleanup: got valid=%b done=%b, want 0 0", out_valid, done);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        out_ready = 1'b1;
        start_pulse();
        k = 0;
        while (k < N) begin
            #1;
            vectors++;
            if (out_data !== model_word(k)) begin
                miscompares++;
                $display("FAIL rstmid_beat%0d: got %h, want %h", k, out_data, model_word(k));
            end
            if (model_word(k) == 8'h5A) break;
            @(negedge clk);
            k++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got valid=%b data=%h last=%b busy=%b done=%b, want all 0",
                     out_valid, out_data, out_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_wait_start: got valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        start_pulse();
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== model_word(0)) begin
            miscompares++;
            $display("FAIL rstmid_restart: got valid=%b data=%h, want 1 %h", out_valid, out_data, model_word(0));
        end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream(0, 1'b0);
        test_stream(1, 1'b0);
        test_stream(2, 1'b0);
        test_stop();
        test_reset_mid();
`ifdef PALGEN_DESC_EN
        desc = 1'b1;
        test_stream(0, 1'b1);
        test_stream(2, 1'b1);
        desc = 1'b0;
`endif
        test_stream(2, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
